// File: rtl/wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : wb_commit_unit
// Brief   : Writeback stage that selects and extends the result, then commits it
//           to a 32x32 register file with bypassed reads and a last-commit
//           forward entry. Define RETIRE_CNT_EN to add the retire counter port.
// Rev     : 1.0
// ============================================================================
module wb_commit_unit #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
`ifdef RETIRE_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] memory_data_i,
  input  logic [2:0]        Op_i,
  input  logic              valid_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              fwd_valid_o,
  output logic [4:0]        fwd_rd_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              err_o
`ifdef RETIRE_CNT_EN
  , output logic [CNT_W-1:0] retire_cnt_o
`endif
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ALU = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_LB  = 3'd5;
  localparam logic [2:0] OP_LBU = 3'd6;

  // x0 has no storage; it is forced to zero at the read ports
  logic [DATA_W-1:0] regs [1:REG_N-1];

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] wdata;
  logic              aligned;
  logic              is_wr_op;
  logic              is_load;
  logic              commit;
  logic              misaligned;

  always_comb begin
    byte_sel = memory_data_i[7:0];
    case (alu_result_i[1:0])
      2'd1:    byte_sel = memory_data_i[15:8];
      2'd2:    byte_sel = memory_data_i[23:16];
      2'd3:    byte_sel = memory_data_i[31:24];
      default: byte_sel = memory_data_i[7:0];
    endcase
    half_sel = alu_result_i[1] ? memory_data_i[31:16] : memory_data_i[15:0];

    wdata    = alu_result_i;
    aligned  = 1'b1;
    is_wr_op = 1'b0;
    is_load  = 1'b0;
    case (Op_i)
      OP_ALU: is_wr_op = 1'b1;
      OP_LW: begin
        wdata    = memory_data_i;
        aligned  = (alu_result_i[1:0] == 2'b00);
        is_wr_op = 1'b1;
        is_load  = 1'b1;
      end
      OP_LH, OP_LHU: begin
        wdata    = (Op_i == OP_LH) ? {{(DATA_W-16){half_sel[15]}}, half_sel}
                                   : {{(DATA_W-16){1'b0}}, half_sel};
        aligned  = ~alu_result_i[0];
        is_wr_op = 1'b1;
        is_load  = 1'b1;
      end
      OP_LB, OP_LBU: begin
        wdata    = (Op_i == OP_LB) ? {{(DATA_W-8){byte_sel[7]}}, byte_sel}
                                   : {{(DATA_W-8){1'b0}}, byte_sel};
        is_wr_op = 1'b1;
        is_load  = 1'b1;
      end
      default: ;
    endcase
  end

  assign commit     = valid_i & is_wr_op & aligned & (rd_i != 5'd0);
  assign misaligned = valid_i & is_load & ~aligned;

  // Write-before-read: a same-cycle commit to the addressed register wins
  always_comb begin
    rs_data_o = '0;
    if (rs_addr_i != 5'd0)
      rs_data_o = (commit && (rd_i == rs_addr_i)) ? wdata : regs[rs_addr_i];
    rt_data_o = '0;
    if (rt_addr_i != 5'd0)
      rt_data_o = (commit && (rd_i == rt_addr_i)) ? wdata : regs[rt_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < REG_N; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[rd_i] <= wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fwd_valid_o <= 1'b0;
      fwd_rd_o    <= 5'd0;
      fwd_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      fwd_valid_o <= commit;
      if (commit) begin
        fwd_rd_o   <= rd_i;
        fwd_data_o <= wdata;
      end
      if (misaligned) err_o <= 1'b1;
    end
  end

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      retire_cnt_o <= '0;
    else if (valid_i && (Op_i != OP_NOP))
      retire_cnt_o <= retire_cnt_o + 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_commit_unit
// Brief   : Self-checking bench for wb_commit_unit (honours RETIRE_CNT_EN).
// Rev     : 1.0
// ============================================================================
module tb_wb_commit_unit;

`ifdef RETIRE_CNT_EN
    localparam int TB_CNT_W = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] memory_data = '0;
    logic [2:0]  op = '0;
    logic        valid = 1'b0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data, rt_data, fwd_data;
    logic        fwd_valid, err;
    logic [4:0]  fwd_rd;
`ifdef RETIRE_CNT_EN
    logic [TB_CNT_W-1:0] retire_cnt;
`endif

    always #5 clk = ~clk;

`ifdef RETIRE_CNT_EN
    wb_commit_unit #(.CNT_W(TB_CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .alu_result_i(alu_result), .memory_data_i(memory_data),
        .Op_i(op), .valid_i(valid), .rd_i(rd),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rs_data_o(rs_data), .rt_data_o(rt_data),
        .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data),
        .err_o(err),
        .retire_cnt_o(retire_cnt)
    );
`else
    wb_commit_unit dut (
        .clk_i(clk), .rst_i(rst_n),
        .alu_result_i(alu_result), .memory_data_i(memory_data),
        .Op_i(op), .valid_i(valid), .rd_i(rd),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rs_data_o(rs_data), .rt_data_o(rt_data),
        .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data),
        .err_o(err)
    );
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    logic [31:0] m_regs [32];
    bit          m_err;
    bit          m_fwd_v;
    logic [4:0]  m_fwd_rd;
    logic [31:0] m_fwd_d;
    int unsigned m_cnt;

    function automatic logic [31:0] model_wdata();
        int unsigned sh;
        logic [31:0] b, h;
        sh = 8 * int'(alu_result % 4);
        b  = (memory_data >> sh) & 32'hFF;
        h  = (alu_result % 4 >= 2) ? (memory_data >> 16) : (memory_data & 32'hFFFF);
        case (op)
            3'd1: return alu_result;
            3'd2: return memory_data;
            3'd3: return (h ^ 32'h8000) - 32'h8000;
            3'd4: return h;
            3'd5: return (b ^ 32'h80) - 32'h80;
            3'd6: return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_misaligned();
        if (!valid) return 0;
        if (op == 3'd2 && (alu_result % 4) != 0) return 1;
        if ((op == 3'd3 || op == 3'd4) && (alu_result % 2) != 0) return 1;
        return 0;
    endfunction

    function automatic bit model_commit();
        if (!valid || op == 3'd0 || op == 3'd7) return 0;
        if (model_misaligned()) return 0;
        return rd != 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (model_commit() && rd == a) return model_wdata();
        return m_regs[a];
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_err = 0; m_fwd_v = 0; m_fwd_rd = '0; m_fwd_d = '0; m_cnt = 0;
    endtask

    task automatic drive(input bit v, input logic [2:0] o, input logic [4:0] d,
                         input logic [31:0] a, input logic [31:0] m,
                         input logic [4:0] s, input logic [4:0] t);
        @(negedge clk);
        valid = v; op = o; rd = d; alu_result = a; memory_data = m;
        rs_addr = s; rt_addr = t;
        #1;
    endtask

    // Advance one posedge and apply the architectural effect of the current inputs
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (model_commit()) begin
                m_regs[rd] = model_wdata();
                m_fwd_rd   = rd;
                m_fwd_d    = model_wdata();
            end
            m_fwd_v = model_commit();
            if (model_misaligned()) m_err = 1;
            if (valid && op != 0) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < 32; a++) begin
            drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 5'(a), 5'(31 - a));
            checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs x%0d got %h exp 0", a, rs_data); end
            checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL reset_rt x%0d got %h exp 0", 31 - a, rt_data); end
        end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid got %b exp 0", fwd_valid); end
        checks++; if (fwd_rd !== 5'd0) begin errors++; $display("FAIL reset_fwd_rd got %0d exp 0", fwd_rd); end
        checks++; if (fwd_data !== 32'h0) begin errors++; $display("FAIL reset_fwd_data got %h exp 0", fwd_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_alu_bypass();
        drive(1, 3'd1, 5'd5, 32'h1234_5678, 32'h0, 5'd5, 5'd0);
        checks++; if (rs_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_bypass got %h exp 12345678", rs_data); end
        checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL alu_x0 got %h exp 0", rt_data); end
        tick();
        checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_fwd_valid got %b exp 1", fwd_valid); end
        checks++; if (fwd_rd !== 5'd5) begin errors++; $display("FAIL alu_fwd_rd got %0d exp 5", fwd_rd); end
        checks++; if (fwd_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_fwd_data got %h exp 12345678", fwd_data); end
        drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
        checks++; if (rt_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_stored got %h exp 12345678", rt_data); end
        tick();
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL idle_fwd_valid got %b exp 0", fwd_valid); end
        checks++; if (fwd_rd !== 5'd5) begin errors++; $display("FAIL idle_fwd_rd_hold got %0d exp 5", fwd_rd); end
    endtask

    task automatic test_byte_loads();
        drive(1, 3'd5, 5'd7, 32'h0000_0003, 32'h80FF_0000, 5'd0, 5'd0);
        tick();
        drive(1, 3'd6, 5'd8, 32'h0000_0003, 32'h80FF_0000, 5'd7, 5'd8);
        checks++; if (rs_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext got %h exp ffffff80", rs_data); end
        checks++; if (rt_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_bypass got %h exp 00000080", rt_data); end
        tick();
        checks++; if (fwd_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_fwd got %h exp 00000080", fwd_data); end
    endtask

    task automatic test_half_misalign();
        drive(1, 3'd3, 5'd9, 32'h0000_0002, 32'h8001_0000, 5'd9, 5'd0);
        checks++; if (rs_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_sext got %h exp ffff8001", rs_data); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lh_err got %b exp 0", err); end
        drive(1, 3'd2, 5'd10, 32'h0000_0002, 32'h1234_5678, 5'd10, 5'd9);
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL lw_mis_nobypass got %h exp 0", rs_data); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL lw_mis_err got %b exp 1", err); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL lw_mis_fwd_valid got %b exp 0", fwd_valid); end
        checks++; if (fwd_rd !== 5'd9) begin errors++; $display("FAIL lw_mis_fwd_rd got %0d exp 9", fwd_rd); end
        drive(1, 3'd1, 5'd11, 32'h0000_0001, 32'h0, 5'd10, 5'd0);
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL lw_mis_nowrite got %h exp 0", rs_data); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_x0_and_invalid();
        drive(1, 3'd1, 5'd0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0);
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL x0_read got %h exp 0", rs_data); end
        tick();
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL x0_fwd_valid got %b exp 0", fwd_valid); end
        drive(0, 3'd1, 5'd12, 32'hCAFE_F00D, 32'h0, 5'd12, 5'd0);
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL invalid_bypass got %h exp 0", rs_data); end
        tick();
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL invalid_fwd_valid got %b exp 0", fwd_valid); end
        drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd0);
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL invalid_nowrite got %h exp 0", rs_data); end
    endtask

    task automatic test_reset_mid_commit();
        drive(1, 3'd1, 5'd3, 32'h55AA_55AA, 32'h0, 5'd3, 5'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err_clear got %b exp 0", err); end
        tick();
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b0;
        drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd5);
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL midreset_lost got %h exp 0", rs_data); end
        checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL midreset_x5 got %h exp 0", rt_data); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL midreset_fwd got %b exp 0", fwd_valid); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            drive(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 9)),
                  a, $urandom, 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
            checks++; if (rs_data !== model_read(rs_addr)) begin errors++; $display("FAIL rand_rs[%0d] got %h exp %h", n, rs_data, model_read(rs_addr)); end
            checks++; if (rt_data !== model_read(rt_addr)) begin errors++; $display("FAIL rand_rt[%0d] got %h exp %h", n, rt_data, model_read(rt_addr)); end
            tick();
            checks++; if (fwd_valid !== m_fwd_v) begin errors++; $display("FAIL rand_fwd_valid[%0d] got %b exp %b", n, fwd_valid, m_fwd_v); end
            checks++; if (fwd_rd !== m_fwd_rd) begin errors++; $display("FAIL rand_fwd_rd[%0d] got %0d exp %0d", n, fwd_rd, m_fwd_rd); end
            checks++; if (fwd_data !== m_fwd_d) begin errors++; $display("FAIL rand_fwd_data[%0d] got %h exp %h", n, fwd_data, m_fwd_d); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err[%0d] got %b exp %b", n, err, m_err); end
`ifdef RETIRE_CNT_EN
            checks++; if (retire_cnt !== TB_CNT_W'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", n, retire_cnt, m_cnt % (1 << TB_CNT_W)); end
`endif
        end
        for (int r = 0; r < 32; r++) begin
            drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 5'(r), 5'(r));
            checks++; if (rs_data !== model_read(5'(r))) begin errors++; $display("FAIL sweep x%0d got %h exp %h", r, rs_data, model_read(5'(r))); end
        end
    endtask

`ifdef RETIRE_CNT_EN
    task automatic test_retire();
        do_reset();
        for (int n = 0; n < 15; n++) begin
            drive(1, 3'd7, 5'($urandom_range(0, 31)), $urandom, $urandom, 5'd0, 5'd0);
            tick();
        end
        checks++; if (retire_cnt !== TB_CNT_W'(15)) begin errors++; $display("FAIL retire_15 got %0d exp 15", retire_cnt); end
        drive(1, 3'd7, 5'd1, 32'h0, 32'h0, 5'd1, 5'd0);
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL store_nowrite got %h exp 0", rs_data); end
        tick();
        checks++; if (retire_cnt !== TB_CNT_W'(0)) begin errors++; $display("FAIL retire_wrap got %0d exp 0", retire_cnt); end
        for (int n = 0; n < 5; n++) begin
            drive(1, 3'd7, 5'd2, 32'h0, 32'h0, 5'd0, 5'd0);
            tick();
        end
        checks++; if (retire_cnt !== TB_CNT_W'(5)) begin errors++; $display("FAIL retire_5 got %0d exp 5", retire_cnt); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (retire_cnt !== TB_CNT_W'(0)) begin errors++; $display("FAIL retire_reset got %0d exp 0", retire_cnt); end
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b0;
        model_reset();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_alu_bypass();
        test_byte_loads();
        test_half_misalign();
        test_x0_and_invalid();
        test_reset_mid_commit();
`ifdef RETIRE_CNT_EN
        test_retire();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
